// File: rtl/hamming7_decoder.sv
// hamming7_decoder
//   Two-stage pipelined Hamming(7,4) single-error-correcting decoder with a
//   saturating count of corrected words.
//
//   Code word layout (code_in[k-1] is position k):
//     pos 1 = p1, 2 = p2, 3 = d1, 4 = p3, 5 = d2, 6 = d3, 7 = d4
//   The syndrome {s3,s2,s1} directly names the flipped position (0 = clean).
//
// Ports
//   clock       rising-edge clock for all state
//   rst_n       asynchronous active-low reset
//   in_valid    code_in carries a word this cycle
//   code_in     received 7-bit code word
//   cnt_clear   synchronous clear of corr_count (wins over an increment)
//   out_valid   data_out / err_pos / err_flag are valid this cycle
//   data_out    corrected data, data_out[0..3] = d1..d4
//   err_flag    word had a nonzero syndrome and was corrected
//   err_pos     corrected position 1..7, 0 when clean
//   corr_count  saturating (255) count of corrected words

module hamming7_decoder (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [6:0] code_in,
  input  logic       cnt_clear,
  output logic       out_valid,
  output logic [3:0] data_out,
  output logic       err_flag,
  output logic [2:0] err_pos,
  output logic [7:0] corr_count
);

  logic [2:0] syn;
  logic       s1_valid;
  logic [6:0] s1_code;
  logic [2:0] s1_syn;
  logic [6:0] flip_mask;
  logic [6:0] fixed_code;
  logic [3:0] fixed_data;
  logic       count_inc;

  // Syndrome of the incoming word.
  always_comb begin
    syn[0] = code_in[0] ^ code_in[2] ^ code_in[4] ^ code_in[6];
    syn[1] = code_in[1] ^ code_in[2] ^ code_in[5] ^ code_in[6];
    syn[2] = code_in[3] ^ code_in[4] ^ code_in[5] ^ code_in[6];
  end

  // Stage 1: capture word and syndrome; data registers hold while idle.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_code <= code_in;
        s1_syn  <= syn;
      end
    end
  end

  // Correction: invert the position named by the syndrome.
  always_comb begin
    flip_mask = '0;
    if (s1_syn != '0) begin
      flip_mask[s1_syn - 3'd1] = 1'b1;
    end
    fixed_code = s1_code ^ flip_mask;
    fixed_data = {fixed_code[6], fixed_code[5], fixed_code[4], fixed_code[2]};
  end

  assign count_inc = s1_valid && (s1_syn != '0);

  // Stage 2: outputs hold their last valid values while out_valid is low.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      err_flag  <= 1'b0;
      err_pos   <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        data_out <= fixed_data;
        err_pos  <= s1_syn;
        err_flag <= (s1_syn != '0);
      end
    end
  end

  // Corrected-word counter; a clear in the same cycle drops that increment.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      corr_count <= '0;
    end else if (cnt_clear) begin
      corr_count <= '0;
    end else if (count_inc && (corr_count != '1)) begin
      corr_count <= corr_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_hamming7_decoder.sv
// tb_hamming7_decoder
//   Directed stimulus for hamming7_decoder. Each driven word pushes its
//   expected result and due cycle onto a scoreboard queue; a monitor pops and
//   compares whenever out_valid rises and also tracks the expected counter.

module tb_hamming7_decoder;

  logic       clock;
  logic       rst_n;
  logic       in_valid;
  logic [6:0] code_in;
  logic       cnt_clear;
  logic       out_valid;
  logic [3:0] data_out;
  logic       err_flag;
  logic [2:0] err_pos;
  logic [7:0] corr_count;

  hamming7_decoder dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .code_in    (code_in),
    .cnt_clear  (cnt_clear),
    .out_valid  (out_valid),
    .data_out   (data_out),
    .err_flag   (err_flag),
    .err_pos    (err_pos),
    .corr_count (corr_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [3:0]  d;
    logic [2:0]  pos;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;
  int unsigned exp_cnt = 0;
  logic [3:0]  last_d    = '0;
  logic [2:0]  last_pos  = '0;
  logic        last_flag = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic p1, p2, p3;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p3 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p3, d[0], p2, p1};
  endfunction

  function automatic logic [6:0] flip(input logic [6:0] c, input logic [2:0] k);
    logic [6:0] r;
    r = c;
    if (k != 3'd0) r[k - 3'd1] = ~r[k - 3'd1];
    return r;
  endfunction

  task automatic drive(input logic v, input logic [6:0] c, input logic clr,
                       input logic [3:0] d, input logic [2:0] pos);
    exp_t e;
    @(negedge clock);
    in_valid  = v;
    code_in   = c;
    cnt_clear = clr;
    if (v) begin
      e.d   = d;
      e.pos = pos;
      e.due = cyc + 2;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(1'b0, 7'd0, 1'b0, 4'd0, 3'd0);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clock) begin
    logic clr_s;
    logic flagged;
    exp_t e;
    cyc++;
    clr_s = cnt_clear;
    #1;
    if (rst_n) begin
      flagged = 1'b0;
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", {31'd0, out_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("latency", cyc, e.due);
          chk("data_out", {28'd0, data_out}, {28'd0, e.d});
          chk("err_pos", {29'd0, err_pos}, {29'd0, e.pos});
          chk("err_flag", {31'd0, err_flag}, {31'd0, (e.pos != 3'd0)});
          last_d    = e.d;
          last_pos  = e.pos;
          last_flag = (e.pos != 3'd0);
          flagged   = (e.pos != 3'd0);
        end
      end else begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          chk("missing_out", {31'd0, out_valid}, 32'd1);
          void'(sb.pop_front());
        end
        chk("hold_data", {28'd0, data_out}, {28'd0, last_d});
        chk("hold_pos", {29'd0, err_pos}, {29'd0, last_pos});
        chk("hold_flag", {31'd0, err_flag}, {31'd0, last_flag});
      end
      if (clr_s) exp_cnt = 0;
      else if (flagged && exp_cnt < 255) exp_cnt++;
      chk("corr_count", {24'd0, corr_count}, exp_cnt);
    end
  end

  initial begin
    int unsigned n_err;
    logic [3:0]  d;
    logic [2:0]  k;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    code_in   = '0;
    cnt_clear = 1'b0;

    // Reset state
    repeat (2) @(negedge clock);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data_out", {28'd0, data_out}, 32'd0);
    chk("rst_err_pos", {29'd0, err_pos}, 32'd0);
    chk("rst_err_flag", {31'd0, err_flag}, 32'd0);
    chk("rst_corr_count", {24'd0, corr_count}, 32'd0);
    rst_n = 1'b1;

    // Clean word d=1011
    drive(1'b1, 7'b1010101, 1'b0, 4'b1011, 3'd0);
    idle(3);
    chk("clean_count", {24'd0, corr_count}, 32'd0);

    // Single-error sweep, back-to-back
    n_err = 0;
    for (int unsigned dv = 0; dv < 16; dv++) begin
      for (int unsigned kv = 0; kv < 8; kv++) begin
        d = dv[3:0];
        k = kv[2:0];
        drive(1'b1, flip(encode(d), k), 1'b0, d, k);
        if (kv != 0) n_err++;
      end
    end
    idle(4);
    chk("sweep_count", {24'd0, corr_count}, n_err);

    // Saturation: 300 one-bit-error words
    for (int unsigned i = 0; i < 300; i++) begin
      d = 4'($urandom_range(0, 15));
      k = 3'($urandom_range(1, 7));
      drive(1'b1, flip(encode(d), k), 1'b0, d, k);
    end
    idle(4);
    chk("sat_count", {24'd0, corr_count}, 32'd255);

    // Clear colliding with a corrected word's stage-2 update
    drive(1'b1, flip(encode(4'd5), 3'd3), 1'b0, 4'd5, 3'd3);
    drive(1'b0, 7'd0, 1'b1, 4'd0, 3'd0);
    idle(2);
    chk("clear_count", {24'd0, corr_count}, 32'd0);
    drive(1'b1, flip(encode(4'd12), 3'd6), 1'b0, 4'd12, 3'd6);
    idle(3);
    chk("after_clear", {24'd0, corr_count}, 32'd1);

    // Gap: valid, idle, valid
    drive(1'b1, encode(4'd9), 1'b0, 4'd9, 3'd0);
    drive(1'b0, 7'd0, 1'b0, 4'd0, 3'd0);
    drive(1'b1, flip(encode(4'd6), 3'd7), 1'b0, 4'd6, 3'd7);
    idle(4);

    // Reset with two words in flight
    drive(1'b1, flip(encode(4'd3), 3'd2), 1'b0, 4'd3, 3'd2);
    drive(1'b1, flip(encode(4'd14), 3'd5), 1'b0, 4'd14, 3'd5);
    @(negedge clock);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_data_out", {28'd0, data_out}, 32'd0);
    chk("midrst_err_pos", {29'd0, err_pos}, 32'd0);
    chk("midrst_err_flag", {31'd0, err_flag}, 32'd0);
    chk("midrst_corr_count", {24'd0, corr_count}, 32'd0);
    sb.delete();
    exp_cnt   = 0;
    last_d    = '0;
    last_pos  = '0;
    last_flag = 1'b0;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    idle(4);
    drive(1'b1, flip(encode(4'd10), 3'd4), 1'b0, 4'd10, 3'd4);
    idle(4);
    chk("post_rst_count", {24'd0, corr_count}, 32'd1);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
